// File: rtl/mem_read_arbiter.sv
// Arbitrates the ICache and DCache read requests onto one memory read channel and routes the returned beats back to the owner.
// Latency: addr_ok in the request cycle, rd_req the next cycle; return beats pass through combinationally. MEM_ARB_RR_EN selects round-robin arbitration.
// Backpressure: one transaction at a time; a losing or newly arriving request stays pending and must be held stable until its addr_ok.
module mem_read_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_rd_req,
    input  logic        i_rd_type,
    input  logic [31:0] i_rd_addr,
    output logic        i_rd_addr_ok,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    input  logic        d_rd_req,
    input  logic        d_rd_type,
    input  logic [31:0] d_rd_addr,
    output logic        d_rd_addr_ok,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] ret_data,
    output logic        rd_req,
    output logic        rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_addr_ok,
    input  logic        mem_ret_valid,
    input  logic        mem_ret_last,
    input  logic [31:0] mem_ret_data,
    output logic        busy,
    output logic        owner,
    output logic        beat_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [CNT_W:0] LINE_BEATS = (CNT_W+1)'(LINE_WORDS);
    localparam logic [CNT_W:0] ONE_BEAT   = (CNT_W+1)'(1);

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic             prefer_d;
    logic             grant_i;
    logic             grant_d;
    logic             in_data;
    logic             beat;
    logic [CNT_W:0]   beat_idx;
    logic [CNT_W:0]   exp_beats;
    logic             bad_beat;

`ifdef MEM_ARB_RR_EN
    logic last_owner;
    // On a tie the requester that did not own the previous transaction wins.
    assign prefer_d = ~last_owner;
`else
    assign prefer_d = 1'b1;
`endif

    assign grant_d = (state == IDLE) & d_rd_req & (~i_rd_req | prefer_d);
    assign grant_i = (state == IDLE) & i_rd_req & ~grant_d;

    assign i_rd_addr_ok = grant_i;
    assign d_rd_addr_ok = grant_d;

    assign in_data  = (state == DATA);
    assign beat     = in_data & mem_ret_valid;
    assign ret_data = in_data ? mem_ret_data : 32'h0;

    assign i_ret_valid = beat & ~owner;
    assign d_ret_valid = beat &  owner;
    assign i_ret_last  = beat & mem_ret_last & ~owner;
    assign d_ret_last  = beat & mem_ret_last &  owner;

    assign rd_req = (state == ADDR);
    assign busy   = (state != IDLE);

    // One bit wider than the counter so a saturated count still compares as "beyond expected".
    assign beat_idx  = {1'b0, beat_cnt} + ONE_BEAT;
    assign exp_beats = rd_type ? LINE_BEATS : ONE_BEAT;
    assign bad_beat  = beat & (mem_ret_last ? (beat_idx != exp_beats) : (beat_idx > exp_beats));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            beat_cnt <= '0;
            rd_type  <= 1'b0;
            rd_addr  <= 32'h0;
            owner    <= 1'b0;
            beat_err <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner <= 1'b0;
`endif
        end else begin
            if (bad_beat) begin
                beat_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        rd_addr <= grant_d ? d_rd_addr : i_rd_addr;
                        rd_type <= grant_d ? d_rd_type : i_rd_type;
                        owner   <= grant_d;
                        state   <= ADDR;
`ifdef MEM_ARB_RR_EN
                        last_owner <= grant_d;
`endif
                    end
                end
                ADDR: begin
                    if (rd_addr_ok) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (mem_ret_valid) begin
                        if (mem_ret_last) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                        end else if (beat_cnt != '1) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
